// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: FSM states,
// parity modes, and data-length clamping used when a frame is latched.
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_RSVD
  } parity_e;

  function automatic logic [3:0] clamp_bits(
    input logic [3:0] req,
    input int         max_bits
  );
    if (int'(req) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
    if (int'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Bus write port of the transmitter: write strobe, word, error clear
// (master drives) and the status byte returned to the bus (slave drives).
interface uart_tx_cfg_if #(
  parameter int DATA_SIZE = 9
);
  logic                 write_data;
  logic [DATA_SIZE-1:0] bus_data;
  logic                 clear_error;
  logic [7:0]           status_register;

  modport master (
    output write_data, bus_data, clear_error,
    input  status_register
  );

  modport slave (
    input  write_data, bus_data, clear_error,
    output status_register
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick when cnt reaches div (period div+1 clk);
// clr restarts the period synchronously.
module uart_baud_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);
  logic [W-1:0] cnt;

  assign tick = (cnt == div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_fifo.sv
// Word FIFO with async read port; clk, reset_n, wr_en/wr_data push,
// rd_en pops, rd_data shows the head word, empty/full flags.
module uart_fifo #(
  parameter int DATA_SIZE = 9,
  parameter int SIZE_FIFO = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 empty,
  output logic                 full
);
  localparam int AW = $clog2(SIZE_FIFO);

  logic [DATA_SIZE-1:0] mem [SIZE_FIFO];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 wr_ok;
  logic                 rd_ok;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART TX: FIFO-buffered words sent LSB-first with runtime
// data length, parity and stop bits. Ports: clk, reset_n, bus (write
// port + status), cfg_*, baud_div, serial_data_out, tx_busy.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_SIZE      = 9,
  parameter int SIZE_FIFO      = 8,
  parameter int BAUD_DIV_W     = 16,
  parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE+1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uart_tx_cfg_if.slave          bus,
  input  logic [3:0]            cfg_data_bits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic [BAUD_DIV_W-1:0] baud_div,
  output logic                  serial_data_out,
  output logic                  tx_busy
);
  tx_state_e state, state_nxt;

  logic [DATA_SIZE-1:0]      fifo_q;
  logic                      fifo_rd;
  logic                      empty;
  logic                      full;
  logic                      err;
  logic                      tick;
  logic                      baud_clr;
  logic                      line_nxt;

  logic [DATA_SIZE-1:0]      lat_data;
  logic [3:0]                lat_bits;
  logic                      lat_pbit;

  logic [DATA_SIZE-1:0]      sh_data;
  logic [3:0]                sh_bits;
  parity_e                   sh_par;
  logic                      sh_stop2;
  logic [BAUD_DIV_W-1:0]     sh_div;
  logic                      sh_pbit;
  logic [BIT_COUNT_SIZE-1:0] bit_cnt;
  logic                      last_bit;
  logic                      has_par;

  uart_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .SIZE_FIFO (SIZE_FIFO)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (bus.write_data),
    .wr_data (bus.bus_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_q),
    .empty   (empty),
    .full    (full)
  );

  uart_baud_gen #(
    .W (BAUD_DIV_W)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (baud_clr),
    .div     (sh_div),
    .tick    (tick)
  );

  // Bits above the configured length are zeroed at latch so parity
  // and the DATA mux only ever see the N active bits.
  always_comb begin
    lat_bits = clamp_bits(cfg_data_bits, DATA_SIZE);
    lat_data = '0;
    for (int i = 0; i < DATA_SIZE; i++)
      lat_data[i] = fifo_q[i] & (i < int'(lat_bits));
    lat_pbit = (^lat_data) ^ (parity_e'(cfg_parity) == PAR_ODD);
  end

  assign last_bit = (bit_cnt == BIT_COUNT_SIZE'(sh_bits - 4'd1));
  assign has_par  = (sh_par == PAR_EVEN) || (sh_par == PAR_ODD);
  assign tx_busy  = (state != TX_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= TX_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      TX_IDLE:   if (!empty) state_nxt = TX_START;
      TX_START:  if (tick) state_nxt = TX_DATA;
      TX_DATA:
        if (tick && last_bit)
          state_nxt = has_par ? TX_PARITY : TX_STOP1;
      TX_PARITY: if (tick) state_nxt = TX_STOP1;
      TX_STOP1:
        if (tick) state_nxt = sh_stop2 ? TX_STOP2 : TX_IDLE;
      TX_STOP2:  if (tick) state_nxt = TX_IDLE;
      default:   state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    line_nxt = 1'b1;
    fifo_rd  = 1'b0;
    baud_clr = 1'b0;
    unique case (state)
      TX_IDLE: begin
        fifo_rd  = !empty;
        baud_clr = 1'b1;
      end
      TX_START:  line_nxt = 1'b0;
      TX_DATA:   line_nxt = sh_data[bit_cnt];
      TX_PARITY: line_nxt = sh_pbit;
      default:   line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) serial_data_out <= 1'b1;
    else          serial_data_out <= line_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_data  <= '0;
      sh_bits  <= 4'(MIN_DATA_BITS);
      sh_par   <= PAR_NONE;
      sh_stop2 <= 1'b0;
      sh_div   <= '0;
      sh_pbit  <= 1'b0;
    end else if (fifo_rd) begin
      sh_data  <= lat_data;
      sh_bits  <= lat_bits;
      sh_par   <= parity_e'(cfg_parity);
      sh_stop2 <= cfg_stop2;
      sh_div   <= baud_div;
      sh_pbit  <= lat_pbit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bit_cnt <= '0;
    else if (state == TX_DATA && tick)
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
  end

  // A dropped write wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    err <= 1'b0;
    else if (bus.write_data && full) err <= 1'b1;
    else if (bus.clear_error)        err <= 1'b0;
  end

  assign bus.status_register = {4'b0, tx_busy, empty, full, err};
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed and random frames
// compared cycle-by-cycle against a frame model built from bit rules.
module tb_uart_tx_cfg;
  localparam int DS = 9;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  cfg_data_bits = 4'd8;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        line;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_SIZE(DS)) bus ();

  uart_tx_cfg #(
    .DATA_SIZE  (DS),
    .SIZE_FIFO  (8),
    .BAUD_DIV_W (16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .cfg_data_bits   (cfg_data_bits),
    .cfg_parity      (cfg_parity),
    .cfg_stop2       (cfg_stop2),
    .baud_div        (baud_div),
    .serial_data_out (line),
    .tx_busy         (busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cyc = 0;

  logic line_q[$];
  logic busy_q[$];
  int   cyc_q[$];
  bit   exp_q[$];
  int   seg_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    line_q.push_back(line);
    busy_q.push_back(busy);
    cyc_q.push_back(cyc);
  end

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_capture();
    @(posedge clk);
    #1;
    line_q.delete();
    busy_q.delete();
    cyc_q.delete();
    exp_q.delete();
    seg_q.delete();
  endtask

  task automatic wr(input logic [DS-1:0] d);
    bus.write_data = 1'b1;
    bus.bus_data   = d;
    @(posedge clk);
    #1;
    wr_cyc = cyc;
    bus.write_data = 1'b0;
  endtask

  task automatic add_bits(bit b, int k);
    repeat (k) exp_q.push_back(b);
  endtask

  // Frame model: start, N data bits LSB first, optional parity, stop(s);
  // every bit held for div+1 clocks.
  task automatic add_frame(int data, int n, int par, bit st2, int div);
    int nn;
    bit p;
    nn = (n < 5) ? 5 : ((n > DS) ? DS : n);
    p = 0;
    add_bits(1'b0, div + 1);
    for (int i = 0; i < nn; i++) begin
      add_bits(bit'((data >> i) & 1), div + 1);
      p ^= bit'((data >> i) & 1);
    end
    if (par == 1) add_bits(p, div + 1);
    if (par == 2) add_bits(~p, div + 1);
    add_bits(1'b1, (div + 1) * (st2 ? 2 : 1));
    seg_q.push_back(exp_q.size());
  endtask

  task automatic add_idle(int k);
    add_bits(1'b1, k);
    seg_q.push_back(exp_q.size());
  endtask

  task automatic check_stream(string tag, bit chk_lat, output int start);
    int base;
    int idx;
    logic [255:0] o;
    logic [255:0] e;
    start = -1;
    for (int i = 0; i < line_q.size(); i++) begin
      if (line_q[i] === 1'b0) begin
        start = i;
        break;
      end
    end
    chk({tag, "_start"}, 256'(start >= 0), 256'(1));
    if (start < 0) return;
    if (chk_lat)
      chk({tag, "_lat"}, 256'(cyc_q[start] - wr_cyc), 256'(2));
    base = 0;
    foreach (seg_q[k]) begin
      o = '0;
      e = '0;
      for (int j = base; j < seg_q[k]; j++) begin
        idx = start + j;
        o[j-base] = (idx < line_q.size()) ? line_q[idx] : 1'bx;
        e[j-base] = exp_q[j];
      end
      chk($sformatf("%s_seg%0d", tag, k), o, e);
      base = seg_q[k];
    end
  endtask

  task automatic run_single(string tag, int data, int n, int par,
                            bit st2, int div);
    int st;
    int len;
    bit allb;
    cfg_data_bits = 4'(n);
    cfg_parity    = 2'(par);
    cfg_stop2     = st2;
    baud_div      = 16'(div);
    begin_capture();
    add_frame(data, n, par, st2, div);
    len = exp_q.size();
    add_idle(8);
    wr(DS'(data));
    tick(exp_q.size() + 6);
    check_stream(tag, 1'b1, st);
    if (st >= 0 && st + len <= busy_q.size()) begin
      allb = 1'b1;
      for (int i = 0; i < len - 1; i++) allb &= busy_q[st+i];
      chk({tag, "_busy"}, 256'({allb, busy_q[st+len-1]}), 256'(2'b10));
    end
  endtask

  initial begin
    int st;
    int base;
    logic [DS-1:0] w;

    bus.write_data  = 1'b0;
    bus.bus_data    = '0;
    bus.clear_error = 1'b0;

    tick(3);
    chk("rst_line", 256'(line), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_status", 256'(bus.status_register), 256'(8'h04));
    reset_n = 1'b1;
    tick(2);

    run_single("8N1_A5", 'hA5, 8, 0, 1'b0, 3);
    run_single("7E2_1B3", 'h1B3, 7, 1, 1'b1, 1);
    run_single("8O1_FF", 'hFF, 8, 2, 1'b0, 1);
    run_single("8E1_00", 'h00, 8, 1, 1'b0, 1);
    run_single("9N1_div0", 'h155, 9, 3, 1'b0, 0);

    for (int r = 0; r < 6; r++)
      run_single($sformatf("rnd%0d", r),
                 int'($urandom_range(0, 511)),
                 int'($urandom_range(2, 12)),
                 int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));

    // FIFO fill while the first frame is on the line
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'd0;
    cfg_stop2     = 1'b0;
    baud_div      = 16'd3;
    begin_capture();
    base = int'($urandom_range(0, 255));
    w = DS'($urandom_range(0, 511));
    add_frame(int'(w), 8, 0, 1'b0, 3);
    wr(w);
    tick(2);
    for (int i = 1; i <= 8; i++) begin
      w = DS'((base + i * 37) & 'hFF);
      add_bits(1'b1, 1);
      add_frame(int'(w), 8, 0, 1'b0, 3);
      wr(w);
    end
    chk("fifo_full", 256'(bus.status_register[2:0]), 256'(3'b010));
    wr(DS'(9'h1FF));
    chk("fifo_drop_err", 256'(bus.status_register[1:0]), 256'(2'b11));
    tick(4);
    chk("err_sticky", 256'(bus.status_register[0]), 256'(1));
    bus.clear_error = 1'b1;
    tick(1);
    bus.clear_error = 1'b0;
    chk("err_clear", 256'(bus.status_register[1:0]), 256'(2'b10));
    bus.clear_error = 1'b1;
    wr(DS'(9'h0AA));
    bus.clear_error = 1'b0;
    chk("err_set_prio", 256'(bus.status_register[0]), 256'(1));
    bus.clear_error = 1'b1;
    tick(1);
    bus.clear_error = 1'b0;
    add_idle(12);
    tick(exp_q.size() + 6);
    check_stream("fifo", 1'b0, st);
    chk("fifo_drained", 256'(bus.status_register), 256'(8'h04));

    // Config change mid-frame only affects the next frame
    cfg_data_bits = 4'd8;
    baud_div      = 16'd2;
    begin_capture();
    add_frame('h0C3, 8, 0, 1'b0, 2);
    wr(DS'(9'h0C3));
    tick(8);
    cfg_data_bits = 4'd5;
    baud_div      = 16'd1;
    add_bits(1'b1, 1);
    add_frame('h1F5, 5, 0, 1'b0, 1);
    wr(DS'(9'h1F5));
    add_idle(8);
    tick(exp_q.size() + 6);
    check_stream("midcfg", 1'b0, st);

    // Reset in the middle of DATA with a word still queued
    cfg_data_bits = 4'd8;
    baud_div      = 16'd3;
    begin_capture();
    wr(DS'(9'h03C));
    wr(DS'(9'h077));
    tick(10);
    reset_n = 1'b0;
    #1;
    chk("midrst_line", 256'(line), 256'(1));
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_empty", 256'(bus.status_register[2]), 256'(1));
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk("postrst_status", 256'(bus.status_register), 256'(8'h04));
    run_single("postrst_5A", 'h5A, 8, 0, 1'b0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
